write_control: RTL and testbench
================================

WRITE_CONTROL -- requirements
Module: write_control

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state on posedge clk.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port live  input  1  run-enable level from the run controller.
REQ-004 SHALL have port trigger  input  1  one-cycle pulse requesting capture of one package.
REQ-005 SHALL have port HALF_PACKAGE_LENGTH  input  10  words per package (HPL).
REQ-006 SHALL have port MEMORY_DEPTH  input  15  circular sample-memory depth in words.
REQ-007 SHALL have port rd_done  input  1  one-cycle pulse: downstream reader has released one package.
REQ-008 SHALL have port live_rising  output  1  one-cycle pulse on a live 0->1 transition, fed to the downstream reader.
REQ-009 SHALL have port wen  output  1  sample-memory write enable.
REQ-010 SHALL have port waddr  output  15  sample-memory write address.
REQ-011 SHALL have port read_start  output  1  one-cycle pulse: one complete package is in memory.
REQ-012 SHALL have port n_pending  output  6  packages written and not yet released.
REQ-013 SHALL have port overflow  output  1  sticky flag: a trigger was dropped for lack of space.

Function
REQ-014 SHALL register live once (live_d); live_rising = live & ~live_d, registered, asserted the cycle after live first reads 1.
REQ-015 SHALL implement states IDLE, WRITE, COMMIT.
REQ-016 IDLE->WRITE on trigger=1 & live=1 & HPL!=0 & space-available; HPL latched into hpl_q at acceptance.
REQ-017 Space-available SHALL be (n_pending+1)*hpl <= MEMORY_DEPTH, computed in 16-bit unsigned arithmetic with no truncation.
REQ-018 Trigger in IDLE with live=1, HPL!=0 and no space SHALL set overflow and be dropped; state stays IDLE.
REQ-019 Trigger while live=0, while HPL=0, or in WRITE/COMMIT SHALL be ignored without setting overflow.
REQ-020 Write timing: the cycle after acceptance, wen=1 and waddr=init_addr.
REQ-021 In WRITE, wen SHALL stay 1 for exactly hpl_q consecutive cycles.
REQ-022 In WRITE, waddr SHALL increment each cycle, wrapping from MEMORY_DEPTH-1 to 0.
REQ-023 WRITE->COMMIT after the hpl_q-th write; wen=0 in COMMIT.
REQ-024 In COMMIT, read_start=1 for one cycle, n_pending increments, and init_addr <= (init_addr+hpl_q) mod MEMORY_DEPTH.
REQ-025 COMMIT->IDLE unconditionally after one cycle; minimum trigger-to-trigger spacing = hpl_q+2 cycles.
REQ-026 n_pending update: +1 on COMMIT, -1 on rd_done.
REQ-027 Simultaneous COMMIT and rd_done SHALL leave n_pending unchanged.
REQ-028 rd_done with n_pending=0 SHALL be ignored (no underflow).
REQ-029 n_pending SHALL never exceed 63; space check blocks acceptance at 63.
REQ-030 live falling during WRITE SHALL NOT abort: the package completes and commits.
REQ-031 live_rising SHALL synchronously clear waddr, init_addr, n_pending, overflow; state->IDLE, wen=0.
REQ-032 live_rising clear SHALL apply mid-WRITE and SHALL take priority over COMMIT and rd_done in the same cycle.
REQ-033 HPL and MEMORY_DEPTH changes SHALL be honoured only at the next acceptance; they are otherwise static during a run.

Reset
REQ-034 rst=1 SHALL asynchronously force IDLE, live_d=0, and all outputs and internal counters (waddr, init_addr, word count, hpl_q) to 0.
REQ-035 The first live sample after rst release with live=1 SHALL produce live_rising.

Structure
REQ-036 Shared package ofc1_pkg SHALL hold ADDR_W=15, HPL_W=10, QUEUE_W=6, and the IDLE/WRITE/COMMIT state encoding, shared with the reader stage.
REQ-037 Rising-edge detection SHALL be one sub-module, edge_detect (rst, clk, in, rise), instantiated for live.

Verification
REQ-038 HPL=4, DEPTH=16, live raised then trigger -> wen 4 cycles, waddr 0,1,2,3, read_start 1 cycle later, n_pending=1.
REQ-039 HPL=5, DEPTH=12, three triggers spaced 7 cycles, no rd_done -> waddr 0-4, then 5-9; third trigger dropped, overflow=1, n_pending=2.
REQ-040 HPL=5, DEPTH=12, rd_done after the first two commits, then 2 triggers -> waddr 10,11,0,1,2 then 3-7 (wrap).
REQ-041 rd_done in the COMMIT cycle with n_pending=1 -> n_pending stays 1; rd_done at n_pending=0 -> stays 0.
REQ-042 live toggled 1->0->1 mid-WRITE at word 2 of 4 -> live_rising pulse, wen=0, waddr=0, n_pending=0, overflow=0, no read_start.
REQ-043 rst asserted mid-WRITE (async, between clock edges) -> all outputs 0 immediately; trigger during WRITE produces no extra write.

Source files
------------

// File: rtl/ofc1_pkg.sv
// Shared definitions for the write stage and the downstream reader stage:
// field widths, the write-controller state encoding and the space check.
package ofc1_pkg;

    localparam int ADDR_W  = 15;
    localparam int HPL_W   = 10;
    localparam int QUEUE_W = 6;

    // Largest package count the queue counter can hold.
    localparam logic [QUEUE_W-1:0] QUEUE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } wc_state_t;

    // True when one more package of hpl words fits behind the n packages
    // already held. The 16-bit product cannot overflow: 64 * 1023 < 2**16.
    function automatic logic space_ok(
        input logic [QUEUE_W-1:0] n,
        input logic [HPL_W-1:0]   hpl,
        input logic [ADDR_W-1:0]  depth
    );
        logic [15:0] need;
        need = (16'(n) + 16'd1) * 16'(hpl);
        return (need <= 16'(depth));
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: rise pulses for one cycle the cycle
// after in is first sampled high.
module edge_detect (
    input  logic rst,
    input  logic clk,
    input  logic in,
    output logic rise
);

    logic in_d;

    // Delay the input once and flag a 0->1 transition as a registered pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_d <= 1'b0;
            rise <= 1'b0;
        end else begin
            in_d <= in;
            rise <= in & ~in_d;
        end
    end

endmodule

// File: rtl/write_control.sv
// Write controller for a circular sample memory: on each accepted trigger
// writes one package of HPL consecutive words, then announces it to the
// reader and tracks how many packages are still held.
module write_control
    import ofc1_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               live,
    input  logic               trigger,
    input  logic [HPL_W-1:0]   HALF_PACKAGE_LENGTH,
    input  logic [ADDR_W-1:0]  MEMORY_DEPTH,
    input  logic               rd_done,
    output logic               live_rising,
    output logic               wen,
    output logic [ADDR_W-1:0]  waddr,
    output logic               read_start,
    output logic [QUEUE_W-1:0] n_pending,
    output logic               overflow
);

    wc_state_t          state_q;
    logic [HPL_W-1:0]   hpl_q;
    logic [ADDR_W-1:0]  depth_q;
    logic [HPL_W-1:0]   word_cnt_q;
    logic [ADDR_W-1:0]  init_addr_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic               wen_q;
    logic               read_start_q;
    logic [QUEUE_W-1:0] n_pending_q;
    logic               overflow_q;

    logic               live_rising_w;
    logic               commit_w;
    logic               accept_req_w;
    logic               fits_w;
    logic [ADDR_W-1:0]  waddr_next_w;
    logic [ADDR_W-1:0]  init_addr_next_w;
    logic [15:0]        init_sum_w;

    edge_detect u_live_edge (
        .rst  (rst),
        .clk  (clk),
        .in   (live),
        .rise (live_rising_w)
    );

    assign commit_w     = (state_q == COMMIT);
    assign accept_req_w = trigger && live && (HALF_PACKAGE_LENGTH != '0);
    assign fits_w       = space_ok(n_pending_q, HALF_PACKAGE_LENGTH, MEMORY_DEPTH)
                          && (n_pending_q != QUEUE_MAX);

    // Next write address and next package base, both wrapping at the latched depth.
    always_comb begin
        waddr_next_w     = (waddr_q == depth_q - 1'b1) ? '0 : waddr_q + 1'b1;
        init_sum_w       = 16'(init_addr_q) + 16'(hpl_q);
        init_addr_next_w = init_addr_q;
        if (init_sum_w >= 16'(depth_q)) begin
            init_addr_next_w = ADDR_W'(init_sum_w - 16'(depth_q));
        end else begin
            init_addr_next_w = ADDR_W'(init_sum_w);
        end
    end

    // Package FSM with registered outputs; a live rising edge restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hpl_q        <= '0;
            depth_q      <= '0;
            word_cnt_q   <= '0;
            init_addr_q  <= '0;
            waddr_q      <= '0;
            wen_q        <= 1'b0;
            read_start_q <= 1'b0;
            n_pending_q  <= '0;
            overflow_q   <= 1'b0;
        end else if (live_rising_w) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            init_addr_q  <= '0;
            waddr_q      <= '0;
            wen_q        <= 1'b0;
            read_start_q <= 1'b0;
            n_pending_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            read_start_q <= 1'b0;

            // A commit and a release in the same cycle cancel out.
            if (commit_w && !rd_done) begin
                n_pending_q <= n_pending_q + 1'b1;
            end else if (!commit_w && rd_done && (n_pending_q != '0)) begin
                n_pending_q <= n_pending_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (accept_req_w) begin
                        if (fits_w) begin
                            state_q    <= WRITE;
                            hpl_q      <= HALF_PACKAGE_LENGTH;
                            depth_q    <= MEMORY_DEPTH;
                            word_cnt_q <= 10'd1;
                            waddr_q    <= init_addr_q;
                            wen_q      <= 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // word_cnt_q counts words already presented on the port.
                    if (word_cnt_q == hpl_q) begin
                        state_q      <= COMMIT;
                        wen_q        <= 1'b0;
                        read_start_q <= 1'b1;
                    end else begin
                        waddr_q    <= waddr_next_w;
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                end
                COMMIT: begin
                    state_q     <= IDLE;
                    init_addr_q <= init_addr_next_w;
                end
                default: begin
                    state_q <= IDLE;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

    assign live_rising = live_rising_w;
    assign wen         = wen_q;
    assign waddr       = waddr_q;
    assign read_start  = read_start_q;
    assign n_pending   = n_pending_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_write_control.sv
// Scoreboard bench for write_control: expected write addresses are queued
// as each package is requested and popped whenever the DUT asserts wen.
module tb_write_control;

    logic        clk;
    logic        rst;
    logic        live;
    logic        trigger;
    logic [9:0]  hpl;
    logic [14:0] depth;
    logic        rd_done;
    logic        live_rising;
    logic        wen;
    logic [14:0] waddr;
    logic        read_start;
    logic [5:0]  n_pending;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;
    int rs_count     = 0;
    int exp_q[$];

    write_control dut (
        .clk                 (clk),
        .rst                 (rst),
        .live                (live),
        .trigger             (trigger),
        .HALF_PACKAGE_LENGTH (hpl),
        .MEMORY_DEPTH        (depth),
        .rd_done             (rd_done),
        .live_rising         (live_rising),
        .wen                 (wen),
        .waddr               (waddr),
        .read_start          (read_start),
        .n_pending           (n_pending),
        .overflow            (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Every write seen on the port must match the next queued address.
    always @(negedge clk) begin
        if (!rst) begin
            if (wen) begin
                if (exp_q.size() > 0) begin
                    check("waddr", int'(waddr), exp_q.pop_front());
                end else begin
                    check("extra_wen", 1, 0);
                end
            end
            if (read_start) rs_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; live = 1'b0; trigger = 1'b0; rd_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rs_count = 0;
    endtask

    task automatic go_live();
        live = 1'b1;
        tick();
        check("live_rising_on", int'(live_rising), 1);
        tick();
        check("live_rising_off", int'(live_rising), 0);
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic push_run(input int base, input int len, input int dep);
        for (int i = 0; i < len; i++) exp_q.push_back((base + i) % dep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; live = 1'b0; trigger = 1'b0; rd_done = 1'b0;
        hpl = 10'd4; depth = 15'd16;
        tick();
        check("rst_wen", int'(wen), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_npend", int'(n_pending), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_rs", int'(read_start), 0);
        check("rst_lr", int'(live_rising), 0);

        // Single package, HPL=4, DEPTH=16; an extra trigger during WRITE is ignored.
        do_reset();
        hpl = 10'd4; depth = 15'd16;
        go_live();
        push_run(0, 4, 16);
        pulse_trigger();
        tick();
        pulse_trigger();
        tick();
        check("a_rs_early", int'(read_start), 0);
        tick();
        check("a_read_start", int'(read_start), 1);
        tick();
        check("a_rs_once", int'(read_start), 0);
        check("a_npend", int'(n_pending), 1);
        repeat (4) tick();
        check("a_q_empty", exp_q.size(), 0);
        check("a_rs_count", rs_count, 1);
        check("a_ovf", int'(overflow), 0);

        // HPL=5, DEPTH=12: two packages fit, the third is dropped.
        do_reset();
        hpl = 10'd5; depth = 15'd12;
        go_live();
        push_run(0, 5, 12);
        pulse_trigger();
        repeat (6) tick();
        push_run(5, 5, 12);
        pulse_trigger();
        repeat (6) tick();
        pulse_trigger();
        repeat (6) tick();
        check("b_ovf", int'(overflow), 1);
        check("b_npend", int'(n_pending), 2);
        check("b_q_empty", exp_q.size(), 0);
        check("b_rs_count", rs_count, 2);

        // Release both, then two more packages wrapping the memory.
        pulse_rd();
        pulse_rd();
        check("c_npend0", int'(n_pending), 0);
        push_run(10, 5, 12);
        pulse_trigger();
        repeat (6) tick();
        push_run(3, 5, 12);
        pulse_trigger();
        repeat (8) tick();
        check("c_q_empty", exp_q.size(), 0);
        check("c_npend", int'(n_pending), 2);
        check("c_ovf_sticky", int'(overflow), 1);

        // rd_done coincident with COMMIT, and rd_done at zero.
        do_reset();
        hpl = 10'd4; depth = 15'd16;
        go_live();
        push_run(0, 4, 16);
        pulse_trigger();
        repeat (6) tick();
        check("d_npend1", int'(n_pending), 1);
        push_run(4, 4, 16);
        pulse_trigger();
        repeat (4) tick();
        check("d_in_commit", int'(read_start), 1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("d_npend_same", int'(n_pending), 1);
        pulse_rd();
        check("d_npend_dec", int'(n_pending), 0);
        pulse_rd();
        check("d_npend_floor", int'(n_pending), 0);

        // live toggled mid-WRITE restarts the run.
        do_reset();
        hpl = 10'd4; depth = 15'd16;
        go_live();
        push_run(0, 4, 16);
        pulse_trigger();
        repeat (6) tick();
        hpl = 10'd20;
        pulse_trigger();
        check("e_ovf_set", int'(overflow), 1);
        hpl = 10'd4;
        push_run(4, 3, 16);
        pulse_trigger();
        live = 1'b0;
        tick();
        live = 1'b1;
        tick();
        check("e_live_rising", int'(live_rising), 1);
        tick();
        check("e_wen", int'(wen), 0);
        check("e_waddr", int'(waddr), 0);
        check("e_npend", int'(n_pending), 0);
        check("e_ovf_clr", int'(overflow), 0);
        repeat (6) tick();
        check("e_rs_count", rs_count, 1);
        check("e_q_empty", exp_q.size(), 0);

        // Asynchronous reset mid-WRITE, then live_rising after release.
        do_reset();
        hpl = 10'd4; depth = 15'd16;
        go_live();
        hpl = 10'd20;
        pulse_trigger();
        check("f_ovf_set", int'(overflow), 1);
        hpl = 10'd4;
        push_run(0, 2, 16);
        pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        #5;
        rst = 1'b1;
        #1;
        check("f_async_wen", int'(wen), 0);
        check("f_async_waddr", int'(waddr), 0);
        check("f_async_npend", int'(n_pending), 0);
        check("f_async_ovf", int'(overflow), 0);
        check("f_async_rs", int'(read_start), 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("f_rise_after_rst", int'(live_rising), 1);
        repeat (8) tick();
        check("f_q_empty", exp_q.size(), 0);
        check("f_rs_count", rs_count, 0);
        check("f_wen_idle", int'(wen), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
